// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the single regfile write port between the in-order
//               pipeline writeback (P, absolute priority) and the long-latency
//               unit (L). Losing L results wait in a small circular buffer.
//               The buffer is visible to two bypass lookup ports. A starvation
//               counter raises stall_req so that buffered L results can drain.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         p_valid,
    input  logic [ADDR_W-1:0]            p_addr,
    input  logic [DATA_W-1:0]            p_data,
    input  logic                         l_valid,
    output logic                         l_ready,
    input  logic [ADDR_W-1:0]            l_addr,
    input  logic [DATA_W-1:0]            l_data,
    output logic                         we,
    output logic [ADDR_W-1:0]            waddr,
    output logic [DATA_W-1:0]            wdata,
    input  logic [ADDR_W-1:0]            q_addr1,
    output logic                         q_hit1,
    output logic [DATA_W-1:0]            q_data1,
    input  logic [ADDR_W-1:0]            q_addr2,
    output logic                         q_hit2,
    output logic [DATA_W-1:0]            q_data2,
    output logic                         stall_req,
    output logic [$clog2(BUF_DEPTH):0]   buf_count
);

    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(BUF_DEPTH);
    localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(STARVE_LIMIT);

    // Buffer storage: vld is separate so killed entries keep their slot.
    logic [BUF_DEPTH-1:0] r_vld;
    logic [ADDR_W-1:0]    r_addr [BUF_DEPTH];
    logic [DATA_W-1:0]    r_data [BUF_DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_STV_W-1:0]   r_starve;
    logic                 r_stall;

    logic                 w_empty;
    logic                 w_head_vld;
    logic                 w_pop;
    logic                 w_l_ready;
    logic                 w_l_acc;
    logic                 w_l_zero;
    logic                 w_p_kill;
    logic                 w_l_kill;
    logic                 w_bypass;
    logic                 w_enq;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic [c_STV_W-1:0]   w_starve_nxt;

    // Arbitration decisions, L handshake and next-state values for counters.
    always_comb begin
        w_empty    = (r_count == '0);
        w_head_vld = !w_empty && r_vld[r_head];
        // A valid head pops only when P is idle; a killed head pops regardless.
        w_pop      = !w_empty && (!p_valid || !r_vld[r_head]);
        w_l_ready  = !rst && ((r_count < c_FULL) || w_pop);
        w_l_acc    = l_valid && w_l_ready;
        w_l_zero   = (l_addr == '0);
        w_p_kill   = p_valid && (p_addr != '0);
        // P is younger than an L accepted in the same cycle, so P overrides it.
        w_l_kill   = w_p_kill && (p_addr == l_addr);
        w_bypass   = w_l_acc && !w_l_zero && !p_valid && w_empty;
        w_enq      = w_l_acc && !w_l_zero && !w_bypass;

        w_count_nxt = r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_pop);

        w_starve_nxt = r_starve;
        if (w_pop || w_empty) begin
            w_starve_nxt = '0;
        end else if (p_valid && w_head_vld && (r_starve != c_STV_MAX)) begin
            w_starve_nxt = r_starve + c_STV_W'(1);
        end
    end

    // Write port mux: P, then buffered head, then direct L bypass.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (!rst) begin
            if (p_valid) begin
                we    = 1'b1;
                waddr = p_addr;
                wdata = p_data;
            end else if (w_head_vld) begin
                we    = 1'b1;
                waddr = r_addr[r_head];
                wdata = r_data[r_head];
            end else if (w_bypass) begin
                we    = 1'b1;
                waddr = l_addr;
                wdata = l_data;
            end
        end
    end

    // Bypass lookups: walk oldest to youngest so the youngest match wins.
    always_comb begin
        logic [c_PTR_W-1:0] w_idx;
        w_idx   = '0;
        q_hit1  = 1'b0;
        q_data1 = '0;
        q_hit2  = 1'b0;
        q_data2 = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            w_idx = r_head + c_PTR_W'(i);
            if (!rst && (c_CNT_W'(i) < r_count) && r_vld[w_idx]) begin
                if ((q_addr1 != '0) && (r_addr[w_idx] == q_addr1)) begin
                    q_hit1  = 1'b1;
                    q_data1 = r_data[w_idx];
                end
                if ((q_addr2 != '0) && (r_addr[w_idx] == q_addr2)) begin
                    q_hit2  = 1'b1;
                    q_data2 = r_data[w_idx];
                end
            end
        end
    end

    // Control state: pointers, occupancy, valid bits, starvation and stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_vld    <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if ((w_pop && (r_head == c_PTR_W'(i))) ||
                    (w_p_kill && (r_addr[i] == p_addr))) begin
                    r_vld[i] <= 1'b0;
                end
            end
            // Enqueue comes last so a full-buffer pop+push into the same slot keeps the new entry.
            if (w_enq) begin
                r_vld[r_tail] <= !w_l_kill;
                r_tail        <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            r_count  <= w_count_nxt;
            r_starve <= w_starve_nxt;
            r_stall  <= (w_starve_nxt >= c_STV_MAX) && (w_count_nxt != '0);
        end
    end

    // Payload storage needs no reset; occupancy is governed by r_vld/r_count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= l_addr;
            r_data[r_tail] <= l_data;
        end
    end

    assign l_ready   = w_l_ready;
    assign stall_req = r_stall;
    assign buf_count = r_count;

`ifndef SYNTHESIS
    // The pipeline must hold writeback while a stall is requested.
    a_no_p_during_stall: assert property (@(posedge clk) disable iff (rst) !(p_valid && stall_req));
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter. Expected
//               regfile writes are queued as stimulus is driven and compared
//               in order whenever the DUT asserts we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 32;
    localparam int BUF_DEPTH    = 2;
    localparam int STARVE_LIMIT = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       p_valid;
    logic [ADDR_W-1:0]          p_addr;
    logic [DATA_W-1:0]          p_data;
    logic                       l_valid;
    logic                       l_ready;
    logic [ADDR_W-1:0]          l_addr;
    logic [DATA_W-1:0]          l_data;
    logic                       we;
    logic [ADDR_W-1:0]          waddr;
    logic [DATA_W-1:0]          wdata;
    logic [ADDR_W-1:0]          q_addr1;
    logic                       q_hit1;
    logic [DATA_W-1:0]          q_data1;
    logic [ADDR_W-1:0]          q_addr2;
    logic                       q_hit2;
    logic [DATA_W-1:0]          q_data2;
    logic                       stall_req;
    logic [$clog2(BUF_DEPTH):0] buf_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W-1:0] exp_a [$];
    logic [DATA_W-1:0] exp_d [$];
    logic [ADDR_W-1:0] mon_a;
    logic [DATA_W-1:0] mon_d;
    logic [DATA_W-1:0] rf5 = '0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .BUF_DEPTH(BUF_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data),
        .l_valid(l_valid), .l_ready(l_ready), .l_addr(l_addr), .l_data(l_data),
        .we(we), .waddr(waddr), .wdata(wdata),
        .q_addr1(q_addr1), .q_hit1(q_hit1), .q_data1(q_data1),
        .q_addr2(q_addr2), .q_hit2(q_hit2), .q_data2(q_data2),
        .stall_req(stall_req), .buf_count(buf_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    task automatic drv(input logic pv, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                       input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
        p_valid = pv; p_addr = pa; p_data = pd;
        l_valid = lv; l_addr = la; l_data = ld;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every regfile write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            chk("sb_write_expected", 64'(exp_a.size() != 0), 64'd1);
            if (exp_a.size() != 0) begin
                mon_a = exp_a.pop_front();
                mon_d = exp_d.pop_front();
                chk("sb_waddr", 64'(waddr), 64'(mon_a));
                chk("sb_wdata", 64'(wdata), 64'(mon_d));
            end
            if (waddr == 5'd5) rf5 = wdata;
        end
    end

    initial begin
        drv(0, 0, 0, 0, 0, 0);
        q_addr1 = '0;
        q_addr2 = '0;
        nxt();

        // Outputs forced quiet while rst is high, even with live inputs.
        drv(0, 0, 0, 1, 5'd7, 32'h77);
        q_addr1 = 5'd7;
        @(negedge clk);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_l_ready", 64'(l_ready), 64'd0);
        chk("rst_q_hit1", 64'(q_hit1), 64'd0);
        chk("rst_q_data1", 64'(q_data1), 64'd0);
        nxt();

        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        q_addr1 = '0;
        @(negedge clk);
        chk("rst_buf_count", 64'(buf_count), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_l_ready_idle", 64'(l_ready), 64'd1);
        chk("rst_idle_we", 64'(we), 64'd0);
        nxt();

        // Idle bypass: L written in the same cycle, nothing buffered.
        drv(0, 0, 0, 1, 5'd7, 32'h55);
        exp_wr(5'd7, 32'h55);
        @(negedge clk);
        chk("byp_we", 64'(we), 64'd1);
        chk("byp_waddr", 64'(waddr), 64'd7);
        chk("byp_wdata", 64'(wdata), 64'h55);
        chk("byp_count", 64'(buf_count), 64'd0);
        nxt();
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("byp_after_count", 64'(buf_count), 64'd0);
        nxt();

        // Contention: P wins, L buffered and visible to lookup, then drains.
        drv(1, 5'd3, 32'h11, 1, 5'd9, 32'h22);
        exp_wr(5'd3, 32'h11);
        @(negedge clk);
        chk("cont_waddr", 64'(waddr), 64'd3);
        chk("cont_l_ready", 64'(l_ready), 64'd1);
        nxt();
        drv(0, 0, 0, 0, 0, 0);
        q_addr1 = 5'd9;
        exp_wr(5'd9, 32'h22);
        @(negedge clk);
        chk("cont_count", 64'(buf_count), 64'd1);
        chk("cont_q_hit1", 64'(q_hit1), 64'd1);
        chk("cont_q_data1", 64'(q_data1), 64'h22);
        chk("cont_drain_waddr", 64'(waddr), 64'd9);
        nxt();
        @(negedge clk);
        chk("cont_drained", 64'(buf_count), 64'd0);
        chk("cont_q_hit1_gone", 64'(q_hit1), 64'd0);
        nxt();
        q_addr1 = '0;

        // Full buffer: P busy for five cycles, three L results offered.
        for (int k = 0; k < 5; k++) begin
            if (k == 0)      drv(1, 5'(k + 1), 32'hA0 + k, 1, 5'd20, 32'h100);
            else if (k == 1) drv(1, 5'(k + 1), 32'hA0 + k, 1, 5'd21, 32'h101);
            else             drv(1, 5'(k + 1), 32'hA0 + k, 1, 5'd22, 32'h102);
            exp_wr(5'(k + 1), 32'hA0 + k);
            @(negedge clk);
            if (k < 2) chk("full_l_ready_open", 64'(l_ready), 64'd1);
            else begin
                chk("full_l_ready_closed", 64'(l_ready), 64'd0);
                chk("full_count", 64'(buf_count), 64'd2);
                chk("full_stall_low", 64'(stall_req), 64'd0);
            end
            nxt();
        end
        // P stops; full buffer with a pop accepts the third L.
        drv(0, 0, 0, 1, 5'd22, 32'h102);
        exp_wr(5'd20, 32'h100);
        @(negedge clk);
        chk("full_stall_high", 64'(stall_req), 64'd1);
        chk("full_pop_l_ready", 64'(l_ready), 64'd1);
        chk("full_count_pop", 64'(buf_count), 64'd2);
        nxt();
        drv(0, 0, 0, 0, 0, 0);
        exp_wr(5'd21, 32'h101);
        @(negedge clk);
        chk("full_stall_clear", 64'(stall_req), 64'd0);
        chk("full_count_keep", 64'(buf_count), 64'd2);
        nxt();
        exp_wr(5'd22, 32'h102);
        @(negedge clk);
        chk("full_count_one", 64'(buf_count), 64'd1);
        nxt();
        @(negedge clk);
        chk("full_count_zero", 64'(buf_count), 64'd0);
        chk("full_idle_we", 64'(we), 64'd0);
        chk("full_idle_stall", 64'(stall_req), 64'd0);
        nxt();

        // WAW kill: buffered L to r5 overridden by a younger P write.
        drv(1, 5'd6, 32'h66, 1, 5'd5, 32'hAA);
        exp_wr(5'd6, 32'h66);
        nxt();
        drv(1, 5'd5, 32'hBB, 0, 0, 0);
        q_addr1 = 5'd5;
        exp_wr(5'd5, 32'hBB);
        @(negedge clk);
        chk("waw_hit_before", 64'(q_hit1), 64'd1);
        chk("waw_data_before", 64'(q_data1), 64'hAA);
        nxt();
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("waw_hit_after", 64'(q_hit1), 64'd0);
        chk("waw_killed_count", 64'(buf_count), 64'd1);
        chk("waw_drain_we", 64'(we), 64'd0);
        nxt();
        @(negedge clk);
        chk("waw_count_zero", 64'(buf_count), 64'd0);
        nxt();
        q_addr1 = '0;

        // Youngest hit: two L results to r4, lookup returns the newer one.
        drv(1, 5'd8, 32'h80, 1, 5'd4, 32'h1);
        exp_wr(5'd8, 32'h80);
        nxt();
        drv(1, 5'd11, 32'h81, 1, 5'd4, 32'h2);
        exp_wr(5'd11, 32'h81);
        nxt();
        drv(0, 0, 0, 0, 0, 0);
        q_addr2 = 5'd4;
        exp_wr(5'd4, 32'h1);
        @(negedge clk);
        chk("young_hit", 64'(q_hit2), 64'd1);
        chk("young_data", 64'(q_data2), 64'h2);
        chk("young_count", 64'(buf_count), 64'd2);
        nxt();
        exp_wr(5'd4, 32'h2);
        @(negedge clk);
        chk("young_data_2", 64'(q_data2), 64'h2);
        chk("young_count_1", 64'(buf_count), 64'd1);
        nxt();
        @(negedge clk);
        chk("young_count_0", 64'(buf_count), 64'd0);
        chk("young_hit_gone", 64'(q_hit2), 64'd0);
        nxt();
        q_addr2 = '0;

        // x0: L to r0 accepted and discarded, both on bypass and under P.
        drv(0, 0, 0, 1, 5'd0, 32'hDEAD);
        @(negedge clk);
        chk("x0_l_ready", 64'(l_ready), 64'd1);
        chk("x0_we", 64'(we), 64'd0);
        chk("x0_q_hit", 64'(q_hit1), 64'd0);
        nxt();
        drv(1, 5'd12, 32'hC0, 1, 5'd0, 32'hBEEF);
        exp_wr(5'd12, 32'hC0);
        nxt();
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("x0_count", 64'(buf_count), 64'd0);
        chk("x0_idle_we", 64'(we), 64'd0);
        nxt();

        // Reset with two entries buffered discards them.
        drv(1, 5'd13, 32'hD0, 1, 5'd14, 32'hE1);
        exp_wr(5'd13, 32'hD0);
        nxt();
        drv(1, 5'd15, 32'hD1, 1, 5'd16, 32'hE2);
        exp_wr(5'd15, 32'hD1);
        nxt();
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        q_addr1 = 5'd14;
        @(negedge clk);
        chk("rst2_count_pre", 64'(buf_count), 64'd2);
        chk("rst2_we", 64'(we), 64'd0);
        chk("rst2_q_hit", 64'(q_hit1), 64'd0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_count", 64'(buf_count), 64'd0);
        chk("rst2_stall", 64'(stall_req), 64'd0);
        chk("rst2_we_after", 64'(we), 64'd0);
        chk("rst2_q_hit_after", 64'(q_hit1), 64'd0);
        nxt();
        @(negedge clk);
        chk("rst2_we_later", 64'(we), 64'd0);
        nxt();

        chk("sb_all_written", 64'(exp_a.size()), 64'd0);
        chk("rf_r5_final", 64'(rf5), 64'hBB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
